// File: rtl/aftab_csr_access_if.sv
// CSR access checker bus: request/verdict handshake plus illegal-access debug state.
interface aftab_csr_access_if #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 reqValid;
  logic                 reqReady;
  logic [ADDR_W-1:0]    reqAddr;
  logic                 reqWrite;
  logic [1:0]           reqPriv;
  logic                 rspValid;
  logic                 rspReady;
  logic                 rspLegal;
  logic [1:0]           rspCause;
  logic [ADDR_W-1:0]    rspAddr;
  logic [ERR_CNT_W-1:0] errCount;
  logic                 firstErrValid;
  logic [ADDR_W-1:0]    firstErrAddr;
  logic                 clrErr;

  modport slave (
    input  reqValid, reqAddr, reqWrite, reqPriv, rspReady, clrErr,
    output reqReady, rspValid, rspLegal, rspCause, rspAddr,
           errCount, firstErrValid, firstErrAddr
  );

  modport master (
    output reqValid, reqAddr, reqWrite, reqPriv, rspReady, clrErr,
    input  reqReady, rspValid, rspLegal, rspCause, rspAddr,
           errCount, firstErrValid, firstErrAddr
  );
endinterface

// File: rtl/aftab_csr_access_ctrl.sv
// Registered CSR access checker: existence, privilege and read-only checks with
// a one-cycle verdict, saturating illegal-access counter and first-fault capture.
module aftab_csr_access_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter bit          EN_USER_CSR = 1'b1,
  parameter bit          EN_MINFO    = 1'b1,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  aftab_csr_access_if.slave   bus
);

  localparam logic [1:0] CAUSE_OK    = 2'b00;
  localparam logic [1:0] CAUSE_NOEX  = 2'b01;
  localparam logic [1:0] CAUSE_PRIV  = 2'b10;
  localparam logic [1:0] CAUSE_RO    = 2'b11;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  if (ADDR_W != 12) begin : g_addr_w_check
    $error("aftab_csr_access_ctrl: ADDR_W must be 12");
  end

  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_legal_q, rsp_legal_d;
  logic [1:0]           rsp_cause_q, rsp_cause_d;
  logic [ADDR_W-1:0]    rsp_addr_q,  rsp_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic                 first_vld_q, first_vld_d;
  logic [ADDR_W-1:0]    first_addr_q, first_addr_d;

  logic                 req_ready;
  logic                 accept;
  logic                 exists;
  logic [1:0]           cause;
  logic                 illegal_acc;

  assign req_ready   = !rsp_valid_q || bus.rspReady;
  assign accept      = bus.reqValid && req_ready;
  assign illegal_acc = accept && (cause != CAUSE_OK);

  // Implemented CSR map; optional groups gated by parameters.
  always_comb begin
    exists = 1'b0;
    case (bus.reqAddr)
      12'h300, 12'h302, 12'h303, 12'h304, 12'h305,
      12'h341, 12'h342, 12'h343, 12'h344:           exists = 1'b1;
      12'h000, 12'h004, 12'h005,
      12'h041, 12'h042, 12'h043, 12'h044:           exists = EN_USER_CSR;
      12'hF11, 12'hF12, 12'hF13, 12'hF14:           exists = EN_MINFO;
      default:                                      exists = 1'b0;
    endcase
  end

  // Cause priority: nonexistent, then privilege, then write to read-only.
  always_comb begin
    cause = CAUSE_OK;
    if (!exists) begin
      cause = CAUSE_NOEX;
    end else if (bus.reqPriv < bus.reqAddr[9:8]) begin
      cause = CAUSE_PRIV;
    end else if ((bus.reqAddr[11:10] == 2'b11) && bus.reqWrite) begin
      cause = CAUSE_RO;
    end
  end

  // Verdict register: load on accept, drop valid when consumed with no new accept.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_legal_d = rsp_legal_q;
    rsp_cause_d = rsp_cause_q;
    rsp_addr_d  = rsp_addr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_legal_d = (cause == CAUSE_OK);
      rsp_cause_d = cause;
      rsp_addr_d  = bus.reqAddr;
    end else if (bus.rspReady) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Error tracking: clear first, then account for the new error in the same cycle.
  always_comb begin
    err_cnt_d    = bus.clrErr ? '0 : err_cnt_q;
    first_vld_d  = bus.clrErr ? 1'b0 : first_vld_q;
    first_addr_d = bus.clrErr ? '0 : first_addr_q;
    if (illegal_acc) begin
      if (err_cnt_d != CNT_MAX) begin
        err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
      end
      if (!first_vld_d) begin
        first_vld_d  = 1'b1;
        first_addr_d = bus.reqAddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_legal_q  <= 1'b0;
      rsp_cause_q  <= CAUSE_OK;
      rsp_addr_q   <= '0;
      err_cnt_q    <= '0;
      first_vld_q  <= 1'b0;
      first_addr_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_legal_q  <= rsp_legal_d;
      rsp_cause_q  <= rsp_cause_d;
      rsp_addr_q   <= rsp_addr_d;
      err_cnt_q    <= err_cnt_d;
      first_vld_q  <= first_vld_d;
      first_addr_q <= first_addr_d;
    end
  end

  assign bus.reqReady      = req_ready;
  assign bus.rspValid      = rsp_valid_q;
  assign bus.rspLegal      = rsp_legal_q;
  assign bus.rspCause      = rsp_cause_q;
  assign bus.rspAddr       = rsp_addr_q;
  assign bus.errCount      = err_cnt_q;
  assign bus.firstErrValid = first_vld_q;
  assign bus.firstErrAddr  = first_addr_q;

endmodule

// File: tb/tb_aftab_csr_access_ctrl.sv
// Directed self-checking bench: default config, EN_MINFO=0 and ERR_CNT_W=2 instances share stimulus.
module tb_aftab_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [11:0] req_addr;
  logic        req_write;
  logic [1:0]  req_priv;
  logic        rsp_ready;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aftab_csr_access_if #(.ADDR_W(12), .ERR_CNT_W(8)) i0 ();
  aftab_csr_access_if #(.ADDR_W(12), .ERR_CNT_W(8)) i1 ();
  aftab_csr_access_if #(.ADDR_W(12), .ERR_CNT_W(2)) i2 ();

  assign i0.reqValid = req_valid; assign i1.reqValid = req_valid; assign i2.reqValid = req_valid;
  assign i0.reqAddr  = req_addr;  assign i1.reqAddr  = req_addr;  assign i2.reqAddr  = req_addr;
  assign i0.reqWrite = req_write; assign i1.reqWrite = req_write; assign i2.reqWrite = req_write;
  assign i0.reqPriv  = req_priv;  assign i1.reqPriv  = req_priv;  assign i2.reqPriv  = req_priv;
  assign i0.rspReady = rsp_ready; assign i1.rspReady = rsp_ready; assign i2.rspReady = rsp_ready;
  assign i0.clrErr   = clr_err;   assign i1.clrErr   = clr_err;   assign i2.clrErr   = clr_err;

  aftab_csr_access_ctrl #(.ADDR_W(12), .EN_USER_CSR(1'b1), .EN_MINFO(1'b1), .ERR_CNT_W(8))
    u_dut0 (.clk(clk), .rst(rst), .bus(i0));
  aftab_csr_access_ctrl #(.ADDR_W(12), .EN_USER_CSR(1'b1), .EN_MINFO(1'b0), .ERR_CNT_W(8))
    u_dut1 (.clk(clk), .rst(rst), .bus(i1));
  aftab_csr_access_ctrl #(.ADDR_W(12), .EN_USER_CSR(1'b1), .EN_MINFO(1'b1), .ERR_CNT_W(2))
    u_dut2 (.clk(clk), .rst(rst), .bus(i2));

  // Advance to just after the next rising edge; all driving and sampling happens there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic w, input logic [1:0] p);
    req_valid = v;
    req_addr  = a;
    req_write = w;
    req_priv  = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_err = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 12'h000, 1'b0, 2'b00);
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (i0.rspValid !== 1'b0) begin bad++; $display("FAIL reset_rspValid got=%b want=0", i0.rspValid); end
    total++; if (i0.rspLegal !== 1'b0) begin bad++; $display("FAIL reset_rspLegal got=%b want=0", i0.rspLegal); end
    total++; if (i0.rspCause !== 2'b00) begin bad++; $display("FAIL reset_rspCause got=%b want=00", i0.rspCause); end
    total++; if (i0.rspAddr !== 12'h000) begin bad++; $display("FAIL reset_rspAddr got=%h want=000", i0.rspAddr); end
    total++; if (i0.errCount !== 8'd0) begin bad++; $display("FAIL reset_errCount got=%0d want=0", i0.errCount); end
    total++; if (i0.firstErrValid !== 1'b0) begin bad++; $display("FAIL reset_firstErrValid got=%b want=0", i0.firstErrValid); end
    total++; if (i0.firstErrAddr !== 12'h000) begin bad++; $display("FAIL reset_firstErrAddr got=%h want=000", i0.firstErrAddr); end
    total++; if (i0.reqReady !== 1'b1) begin bad++; $display("FAIL reset_reqReady got=%b want=1", i0.reqReady); end
  endtask

  task automatic test_legal();
    drive(1'b1, 12'h305, 1'b1, 2'b11);
    step();
    total++; if (i0.rspValid !== 1'b1) begin bad++; $display("FAIL legal_rspValid got=%b want=1", i0.rspValid); end
    total++; if (i0.rspLegal !== 1'b1) begin bad++; $display("FAIL legal_rspLegal got=%b want=1", i0.rspLegal); end
    total++; if (i0.rspCause !== 2'b00) begin bad++; $display("FAIL legal_rspCause got=%b want=00", i0.rspCause); end
    total++; if (i0.rspAddr !== 12'h305) begin bad++; $display("FAIL legal_rspAddr got=%h want=305", i0.rspAddr); end
    total++; if (i0.errCount !== 8'd0) begin bad++; $display("FAIL legal_errCount got=%0d want=0", i0.errCount); end
  endtask

  task automatic test_nonexist();
    drive(1'b1, 12'h001, 1'b0, 2'b11);
    step();
    total++; if (i0.rspCause !== 2'b01) begin bad++; $display("FAIL noex1_cause got=%b want=01", i0.rspCause); end
    total++; if (i0.rspLegal !== 1'b0) begin bad++; $display("FAIL noex1_legal got=%b want=0", i0.rspLegal); end
    total++; if (i0.errCount !== 8'd1) begin bad++; $display("FAIL noex1_errCount got=%0d want=1", i0.errCount); end
    total++; if (i0.firstErrValid !== 1'b1) begin bad++; $display("FAIL noex1_firstValid got=%b want=1", i0.firstErrValid); end
    total++; if (i0.firstErrAddr !== 12'h001) begin bad++; $display("FAIL noex1_firstAddr got=%h want=001", i0.firstErrAddr); end
    drive(1'b1, 12'h7FF, 1'b0, 2'b11);
    step();
    total++; if (i0.rspCause !== 2'b01) begin bad++; $display("FAIL noex2_cause got=%b want=01", i0.rspCause); end
    total++; if (i0.rspAddr !== 12'h7FF) begin bad++; $display("FAIL noex2_addr got=%h want=7ff", i0.rspAddr); end
    total++; if (i0.errCount !== 8'd2) begin bad++; $display("FAIL noex2_errCount got=%0d want=2", i0.errCount); end
    total++; if (i0.firstErrAddr !== 12'h001) begin bad++; $display("FAIL noex2_firstAddr got=%h want=001", i0.firstErrAddr); end
  endtask

  task automatic test_priv_ro();
    drive(1'b1, 12'h341, 1'b0, 2'b00);
    step();
    total++; if (i0.rspCause !== 2'b10) begin bad++; $display("FAIL priv_341u_cause got=%b want=10", i0.rspCause); end
    drive(1'b1, 12'h041, 1'b1, 2'b00);
    step();
    total++; if (i0.rspCause !== 2'b00) begin bad++; $display("FAIL priv_041u_cause got=%b want=00", i0.rspCause); end
    total++; if (i0.rspLegal !== 1'b1) begin bad++; $display("FAIL priv_041u_legal got=%b want=1", i0.rspLegal); end
    drive(1'b1, 12'hF11, 1'b1, 2'b11);
    step();
    total++; if (i0.rspCause !== 2'b11) begin bad++; $display("FAIL ro_f11w_cause got=%b want=11", i0.rspCause); end
    total++; if (i1.rspCause !== 2'b01) begin bad++; $display("FAIL nominfo_f11w_cause got=%b want=01", i1.rspCause); end
    drive(1'b1, 12'hF11, 1'b0, 2'b11);
    step();
    total++; if (i0.rspCause !== 2'b00) begin bad++; $display("FAIL ro_f11r_cause got=%b want=00", i0.rspCause); end
    total++; if (i1.rspCause !== 2'b01) begin bad++; $display("FAIL nominfo_f11r_cause got=%b want=01", i1.rspCause); end
    total++; if (i0.errCount !== 8'd4) begin bad++; $display("FAIL priv_errCount got=%0d want=4", i0.errCount); end
    total++; if (i1.errCount !== 8'd5) begin bad++; $display("FAIL nominfo_errCount got=%0d want=5", i1.errCount); end
    drive(1'b0, 12'h123, 1'b1, 2'b00);
    step();
    total++; if (i0.rspValid !== 1'b0) begin bad++; $display("FAIL drain_rspValid got=%b want=0", i0.rspValid); end
    total++; if (i0.rspAddr !== 12'hF11) begin bad++; $display("FAIL drain_rspAddr got=%h want=f11", i0.rspAddr); end
    total++; if (i0.rspLegal !== 1'b1) begin bad++; $display("FAIL drain_rspLegal got=%b want=1", i0.rspLegal); end
  endtask

  task automatic test_stall();
    logic [11:0] addrs [4];
    logic [1:0]  causes [4];
    addrs  = '{12'h300, 12'h302, 12'h001, 12'hF12};
    causes = '{2'b00, 2'b00, 2'b01, 2'b00};
    rsp_ready = 1'b1;
    drive(1'b1, 12'h300, 1'b0, 2'b11);
    step();
    total++; if (i0.rspAddr !== 12'h300) begin bad++; $display("FAIL stall_first_addr got=%h want=300", i0.rspAddr); end
    rsp_ready = 1'b0;
    drive(1'b1, 12'h999, 1'b0, 2'b11);
    #1;
    total++; if (i0.reqReady !== 1'b0) begin bad++; $display("FAIL stall_reqReady got=%b want=0", i0.reqReady); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (i0.rspValid !== 1'b1 || i0.rspAddr !== 12'h300 || i0.rspCause !== 2'b00 || i0.rspLegal !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b a=%h c=%b l=%b want v=1 a=300 c=00 l=1",
                 i, i0.rspValid, i0.rspAddr, i0.rspCause, i0.rspLegal);
      end
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (i0.reqReady !== 1'b1) begin bad++; $display("FAIL release_reqReady got=%b want=1", i0.reqReady); end
    step();
    total++; if (i0.rspAddr !== 12'h999 || i0.rspCause !== 2'b01) begin
      bad++; $display("FAIL release_verdict got a=%h c=%b want a=999 c=01", i0.rspAddr, i0.rspCause); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, addrs[i], 1'b0, 2'b11);
      step();
      total++;
      if (i0.rspValid !== 1'b1 || i0.rspAddr !== addrs[i] || i0.rspCause !== causes[i]) begin
        bad++;
        $display("FAIL stream idx=%0d got v=%b a=%h c=%b want v=1 a=%h c=%b",
                 i, i0.rspValid, i0.rspAddr, i0.rspCause, addrs[i], causes[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 12'h000, 1'b0, 2'b11);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++; if (i2.errCount !== 2'd0 || i2.firstErrValid !== 1'b0 || i2.firstErrAddr !== 12'h000) begin
      bad++; $display("FAIL clr_only got cnt=%0d fv=%b fa=%h want 0 0 000", i2.errCount, i2.firstErrValid, i2.firstErrAddr); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'h7F0 + 12'(i), 1'b0, 2'b11);
      step();
      total++;
      if (i2.errCount !== exp_cnt[i]) begin
        bad++; $display("FAIL sat_count idx=%0d got=%0d want=%0d", i, i2.errCount, exp_cnt[i]);
      end
    end
    total++; if (i2.firstErrAddr !== 12'h7F0) begin bad++; $display("FAIL sat_firstAddr got=%h want=7f0", i2.firstErrAddr); end
    total++; if (i0.errCount !== 8'd5) begin bad++; $display("FAIL nosat_count got=%0d want=5", i0.errCount); end
    drive(1'b1, 12'h003, 1'b0, 2'b11);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total++; if (i2.errCount !== 2'd1 || i2.firstErrAddr !== 12'h003 || i2.firstErrValid !== 1'b1) begin
      bad++; $display("FAIL clr_err_same got cnt=%0d fa=%h fv=%b want 1 003 1", i2.errCount, i2.firstErrAddr, i2.firstErrValid); end
    total++; if (i0.errCount !== 8'd1 || i0.firstErrAddr !== 12'h003) begin
      bad++; $display("FAIL clr_err_same0 got cnt=%0d fa=%h want 1 003", i0.errCount, i0.firstErrAddr); end
    total++; if (i0.rspCause !== 2'b01 || i0.rspValid !== 1'b1) begin
      bad++; $display("FAIL clr_rsp_unaffected got c=%b v=%b want 01 1", i0.rspCause, i0.rspValid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    drive(1'b1, 12'h001, 1'b0, 2'b11);
    step();
    rsp_ready = 1'b0;
    drive(1'b1, 12'h002, 1'b1, 2'b11);
    rst = 1'b1;
    clr_err = 1'b1;
    step();
    total++; if (i0.rspValid !== 1'b0 || i0.rspAddr !== 12'h000 || i0.rspCause !== 2'b00 || i0.rspLegal !== 1'b0) begin
      bad++; $display("FAIL midrst_rsp got v=%b a=%h c=%b l=%b want 0 000 00 0", i0.rspValid, i0.rspAddr, i0.rspCause, i0.rspLegal); end
    total++; if (i0.errCount !== 8'd0 || i0.firstErrValid !== 1'b0 || i0.firstErrAddr !== 12'h000) begin
      bad++; $display("FAIL midrst_err got cnt=%0d fv=%b fa=%h want 0 0 000", i0.errCount, i0.firstErrValid, i0.firstErrAddr); end
    total++; if (i0.reqReady !== 1'b1) begin bad++; $display("FAIL midrst_reqReady got=%b want=1", i0.reqReady); end
    drive(1'b0, 12'h000, 1'b0, 2'b00);
    step();
    rst = 1'b0;
    step();
    total++; if (i0.rspValid !== 1'b0 || i0.errCount !== 8'd0 || i0.firstErrValid !== 1'b0) begin
      bad++; $display("FAIL clr_during_rst got v=%b cnt=%0d fv=%b want 0 0 0", i0.rspValid, i0.errCount, i0.firstErrValid); end
    clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legal();
    test_nonexist();
    test_priv_ro();
    test_stall();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
